// File: rtl/alu_serial_slice.sv
// Multi-cycle ALU: one SLICE-bit datapath is reused over WIDTH/SLICE cycles, LSB slice first,
// with the inter-slice carry held in a register. Start is honoured only when idle.
module alu_serial_slice #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] o,
  output logic             cout,
  output logic             zero
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [3:0]       s_r;
  logic             m_r;
  logic             carry;

  logic [SLICE-1:0] a_sl;
  logic [SLICE-1:0] b_sl;
  logic [SLICE-1:0] p;
  logic [SLICE-1:0] q;
  logic [SLICE-1:0] f;
  logic [SLICE:0]   sum;
  logic [SLICE-1:0] slice_res;
  logic             slice_cout;
  logic [WIDTH-1:0] o_next;

  always_comb begin
    a_sl = a_r[idx*SLICE +: SLICE];
    b_sl = b_r[idx*SLICE +: SLICE];

    f = '0;
    unique case (s_r)
      4'h0: f = ~a_sl;
      4'h1: f = ~(a_sl | b_sl);
      4'h2: f = ~a_sl & b_sl;
      4'h3: f = '0;
      4'h4: f = ~(a_sl & b_sl);
      4'h5: f = ~b_sl;
      4'h6: f = a_sl ^ b_sl;
      4'h7: f = a_sl & ~b_sl;
      4'h8: f = ~a_sl | b_sl;
      4'h9: f = ~(a_sl ^ b_sl);
      4'hA: f = b_sl;
      4'hB: f = a_sl & b_sl;
      4'hC: f = '1;
      4'hD: f = a_sl | ~b_sl;
      4'hE: f = a_sl | b_sl;
      4'hF: f = a_sl;
      default: f = '0;
    endcase

    p = '0;
    q = '0;
    unique case (s_r)
      4'h0: begin p = a_sl;            q = '0;            end
      4'h1: begin p = a_sl | b_sl;     q = '0;            end
      4'h2: begin p = a_sl | ~b_sl;    q = '0;            end
      4'h3: begin p = '0;              q = '1;            end
      4'h4: begin p = a_sl;            q = a_sl & ~b_sl;  end
      4'h5: begin p = a_sl | b_sl;     q = a_sl & ~b_sl;  end
      4'h6: begin p = a_sl;            q = ~b_sl;         end
      4'h7: begin p = a_sl & ~b_sl;    q = '1;            end
      4'h8: begin p = a_sl;            q = a_sl & b_sl;   end
      4'h9: begin p = a_sl;            q = b_sl;          end
      4'hA: begin p = a_sl | ~b_sl;    q = a_sl & b_sl;   end
      4'hB: begin p = a_sl & b_sl;     q = '1;            end
      4'hC: begin p = a_sl;            q = a_sl;          end
      4'hD: begin p = a_sl | b_sl;     q = a_sl;          end
      4'hE: begin p = a_sl | ~b_sl;    q = a_sl;          end
      4'hF: begin p = a_sl;            q = '1;            end
      default: begin p = '0;           q = '0;            end
    endcase

    sum        = {1'b0, p} + {1'b0, q} + {{SLICE{1'b0}}, carry};
    slice_res  = m_r ? f : sum[SLICE-1:0];
    slice_cout = m_r ? 1'b0 : sum[SLICE];

    o_next = o;
    o_next[idx*SLICE +: SLICE] = slice_res;
  end

  // done/cout/zero are set on the edge that writes the final slice, so they
  // appear together with the complete result; the DONE state then retires them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      idx   <= '0;
      a_r   <= '0;
      b_r   <= '0;
      s_r   <= '0;
      m_r   <= 1'b0;
      carry <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      o     <= '0;
      cout  <= 1'b0;
      zero  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            s_r   <= s;
            m_r   <= m;
            carry <= cin;
            idx   <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          o     <= o_next;
          carry <= slice_cout;
          if (idx == IW'(NSLICE - 1)) begin
            done  <= 1'b1;
            cout  <= slice_cout;
            zero  <= (o_next == '0);
            state <= ST_DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          idx   <= '0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_slice.sv
// Randomized scoreboard bench for alu_serial_slice against a full-width reference model.
module tb_alu_serial_slice;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   s;
  logic         m;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] o;
  logic         cout;
  logic         zero;

  int n_cmp = 0;
  int n_bad = 0;

  // {cout, zero, o}
  logic [W+1:0] exp_q[$];

  alu_serial_slice #(.WIDTH(16), .SLICE(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .s     (s),
    .m     (m),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .o     (o),
    .cout  (cout),
    .zero  (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // Single-cycle whole-word evaluation of the function table; returns {cout, o}.
  function automatic logic [W:0] ref_alu(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                         input logic [3:0] rs, input logic rm, input logic rc);
    logic [W-1:0] pp;
    logic [W-1:0] qq;
    logic [W-1:0] ff;
    if (rm) begin
      case (rs)
        4'h0: ff = ~ra;
        4'h1: ff = ~(ra | rb);
        4'h2: ff = ~ra & rb;
        4'h3: ff = 16'h0000;
        4'h4: ff = ~(ra & rb);
        4'h5: ff = ~rb;
        4'h6: ff = ra ^ rb;
        4'h7: ff = ra & ~rb;
        4'h8: ff = ~ra | rb;
        4'h9: ff = ~(ra ^ rb);
        4'hA: ff = rb;
        4'hB: ff = ra & rb;
        4'hC: ff = 16'hFFFF;
        4'hD: ff = ra | ~rb;
        4'hE: ff = ra | rb;
        default: ff = ra;
      endcase
      return {1'b0, ff};
    end
    case (rs)
      4'h0: begin pp = ra;       qq = 16'h0000; end
      4'h1: begin pp = ra | rb;  qq = 16'h0000; end
      4'h2: begin pp = ra | ~rb; qq = 16'h0000; end
      4'h3: begin pp = 16'h0000; qq = 16'hFFFF; end
      4'h4: begin pp = ra;       qq = ra & ~rb; end
      4'h5: begin pp = ra | rb;  qq = ra & ~rb; end
      4'h6: begin pp = ra;       qq = ~rb;      end
      4'h7: begin pp = ra & ~rb; qq = 16'hFFFF; end
      4'h8: begin pp = ra;       qq = ra & rb;  end
      4'h9: begin pp = ra;       qq = rb;       end
      4'hA: begin pp = ra | ~rb; qq = ra & rb;  end
      4'hB: begin pp = ra & rb;  qq = 16'hFFFF; end
      4'hC: begin pp = ra;       qq = ra;       end
      4'hD: begin pp = ra | rb;  qq = ra;       end
      4'hE: begin pp = ra | ~rb; qq = ra;       end
      default: begin pp = ra;    qq = 16'hFFFF; end
    endcase
    return {1'b0, pp} + {1'b0, qq} + {16'h0000, rc};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    logic [W+1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: got done with o=0x%0h, required no done", o);
        end else begin
          e = exp_q.pop_front();
          chk("result_o_cout_zero", {14'h0, cout, zero, o}, {14'h0, e});
        end
      end
    end
  end

  task automatic scramble();
    a   = W'($urandom);
    b   = W'($urandom);
    s   = 4'($urandom);
    m   = 1'($urandom);
    cin = 1'($urandom);
  endtask

  // Issue one operation; with junk set, inputs and start are disturbed while it runs.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic [3:0] ts,
                        input logic tm, input logic tc, input bit junk);
    logic [W:0] r;
    int n;
    r = ref_alu(ta, tb_, ts, tm, tc);
    @(negedge clk);
    a = ta; b = tb_; s = ts; m = tm; cin = tc;
    start = 1'b1;
    exp_q.push_back({r[W], (r[W-1:0] == 16'h0000), r[W-1:0]});
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    n = 0;
    while (done !== 1'b1 && n < 12) begin
      if (junk) begin
        scramble();
        start = 1'($urandom);
      end
      @(posedge clk);
      #1;
      n++;
    end
    // done is first seen after 4 further edges, i.e. in the 5th cycle after accept
    chk("done_latency", 32'(n), 32'd4);
    chk("busy_in_done", 32'(busy), 32'd1);
    if (junk) begin
      scramble();
      start = 1'b1;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("busy_cleared", 32'(busy), 32'd0);
    chk("o_held", 32'(o), 32'(r[W-1:0]));
  endtask

  initial begin
    int dcount;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; s = '0; m = 1'b0; cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_o", 32'(o), 32'd0);
    chk("reset_cout", 32'(cout), 32'd0);
    chk("reset_zero", 32'(zero), 32'd0);
    rst = 1'b0;

    run_op(16'h1234, 16'h4321, 4'h9, 1'b0, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 4'h9, 1'b0, 1'b0, 1'b0);
    run_op(16'h0005, 16'h0007, 4'h6, 1'b0, 1'b1, 1'b0);
    run_op(16'h0007, 16'h0005, 4'h6, 1'b0, 1'b1, 1'b0);
    run_op(16'hF0F0, 16'hFF00, 4'h6, 1'b1, 1'b0, 1'b0);
    run_op(16'hF0F0, 16'hFF00, 4'h3, 1'b1, 1'b1, 1'b0);
    run_op(16'hF0F0, 16'hFF00, 4'hC, 1'b1, 1'b0, 1'b0);
    run_op(16'hABCD, 16'h1357, 4'h9, 1'b0, 1'b1, 1'b1);
    run_op(16'h8000, 16'h8000, 4'hC, 1'b0, 1'b0, 1'b1);

    // Reset while slice 2 is about to be computed; no done must follow.
    @(negedge clk);
    a = 16'h1234; b = 16'h4321; s = 4'h9; m = 1'b0; cin = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrun_reset_busy", 32'(busy), 32'd0);
    chk("midrun_reset_done", 32'(done), 32'd0);
    chk("midrun_reset_o", 32'(o), 32'd0);
    chk("midrun_reset_cout", 32'(cout), 32'd0);
    dcount = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) dcount++;
    end
    chk("no_done_after_reset", 32'(dcount), 32'd0);
    run_op(16'h00FF, 16'h0001, 4'h9, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      run_op(W'($urandom), W'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom));
    end

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_serial_slice.md
Name: alu_serial_slice

Overview:
- Multi-cycle 16-bit ALU that reuses a single 4-bit slice datapath over WIDTH/SLICE cycles.
- Processes the least-significant slice first and registers the inter-slice carry.
- Area-reduced alternative to the parallel bit-sliced ALU, for datapaths that tolerate latency.
- Same function-select encoding (m, s[3:0], cin); start/busy/done handshake toward the controlling sequencer.

Parameters:
WIDTH, 16, operand/result width; must be a multiple of SLICE
SLICE, 4, bits processed per cycle; NSLICE = WIDTH/SLICE

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request; sampled only in IDLE
a  input  WIDTH  operand A, captured on accepted start
b  input  WIDTH  operand B, captured on accepted start
s  input  4  function select, captured on accepted start
m  input  1  1 = logic mode, 0 = arithmetic mode, captured on accepted start
cin  input  1  carry-in, active-high (1 adds one), captured on accepted start
busy  output  1  high from the cycle after accept through the done cycle
done  output  1  one-cycle pulse; o/cout/zero valid from this cycle
o  output  WIDTH  result, held until next accepted start
cout  output  1  carry out of MSB (arithmetic); 0 in logic mode
zero  output  1  o == 0

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, slice index=0, busy=0, done=0, o=0, cout=0, zero=0. This overrides everything, including mid-operation; the partial result is discarded.
- States and transitions:
  - IDLE: start=1 latches a, b, s, m, cin; sets carry register = cin; moves to RUN with idx=0.
  - RUN: each cycle computes slice idx, writes o[idx*SLICE +: SLICE], and updates the carry register with that slice's carry out. At idx=NSLICE-1, moves to DONE; otherwise idx+1.
  - DONE: done=1, cout=carry register, zero=(o==0); moves to IDLE.
- Latency: start accepted at edge k -> done high during cycle k+NSLICE+1 (5 for defaults). One operation per NSLICE+2 cycles maximum.
- start in RUN or DONE is ignored, not queued.
- Operands are not re-sampled mid-operation; input changes after accept have no effect.
- o updates slice-by-slice during RUN. Consumers use o only at or after done.
- Logic mode (m=1), bitwise, carry ignored, cout=0. Function by s:
  - 0 ~A, 1 ~(A|B), 2 ~A&B, 3 all-0
  - 4 ~(A&B), 5 ~B, 6 A^B, 7 A&~B
  - 8 ~A|B, 9 ~(A^B), A B, B A&B
  - C all-1, D A|~B, E A|B, F A
- Arithmetic mode (m=0): F = P + Q + cin over the full width, computed slice-wise with the registered ripple carry. cout = carry out of bit WIDTH-1. (P,Q) by s:
  - 0 (A,0), 1 (A|B,0), 2 (A|~B,0), 3 (0,all-1)
  - 4 (A,A&~B), 5 (A|B,A&~B), 6 (A,~B), 7 (A&~B,all-1)
  - 8 (A,A&B), 9 (A,B), A (A|~B,A&B), B (A&B,all-1)
  - C (A,A), D (A|B,A), E (A|~B,A), F (A,all-1)
- Subtraction is s=6 with cin=1; cout=1 means no borrow.
- Result must equal the single-cycle WIDTH-bit evaluation of the same table for all inputs.

Test Plan:
1. m=0 s=9 cin=0 a=0x1234 b=0x4321, start pulse -> busy next cycle; done 5 cycles after accept; o=0x5555 cout=0 zero=0.
2. m=0 s=9 cin=0 a=0xFFFF b=0x0001 -> o=0x0000 cout=1 zero=1 (carry ripples through all 4 slices).
3. m=0 s=6 cin=1 a=0x0005 b=0x0007 -> o=0xFFFE cout=0; then a=0x0007 b=0x0005 -> o=0x0002 cout=1.
4. m=1 s=6 a=0xF0F0 b=0xFF00 -> o=0x0FF0 cout=0; m=1 s=3 -> o=0x0000 zero=1; m=1 s=C -> o=0xFFFF.
5. Second start with different operands during RUN and during DONE -> ignored, first result unchanged. Start in the cycle after done -> accepted; correct second result 5 cycles later.
6. rst=1 during RUN at idx=2 -> next cycle busy=0 done=0 o=0 cout=0. No done pulse follows. A new add 0x00FF+0x0001 then gives o=0x0100 cout=0.
